// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, opcodes, status bit indices and FSM encoding
//            for the ALU sequencer.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int WORD_W = 20;
  localparam int HALF_W = 10;
  localparam int CNT_W  = 5;

  localparam int CARRY = 2;
  localparam int SIGN  = 1;
  localparam int ZERO  = 0;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
  localparam logic [3:0] OP_ADD  = 4'd12;
  localparam logic [3:0] OP_SUB  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_LDSR = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        status_t;

  function automatic word_t width_mask(input logic mode);
    return mode ? {WORD_W{1'b1}} : word_t'({HALF_W{1'b1}});
  endfunction

  function automatic logic msb_of(input word_t v, input logic mode);
    return mode ? v[WORD_W-1] : v[HALF_W-1];
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational single-step ALU; shifts/rotates move one bit.
// Revision : 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       mode_i,
  input  word_t      a_i,
  input  word_t      b_i,
  input  status_t    status_i,
  output word_t      c_o,
  output word_t      d_o,
  output status_t    status_o
);

  word_t           mask;
  word_t           am;
  word_t           bm;
  word_t           top;
  logic            a_msb;
  logic            upd_sz;
  logic [WORD_W:0] sum;

  always_comb begin
    mask     = width_mask(mode_i);
    am       = a_i & mask;
    bm       = b_i & mask;
    top      = ~(mask >> 1) & mask;
    a_msb    = msb_of(am, mode_i);
    sum      = '0;
    c_o      = '0;
    d_o      = '0;
    status_o = status_i;
    upd_sz   = 1'b1;
    case (op_i)
      OP_NOT: c_o = ~am & mask;
      OP_AND: c_o = am & bm;
      OP_OR:  c_o = am | bm;
      OP_XOR: c_o = am ^ bm;
      OP_SHL: begin
        c_o             = (am << 1) & mask;
        status_o[CARRY] = a_msb;
      end
      OP_SHR: begin
        c_o             = am >> 1;
        status_o[CARRY] = am[0];
      end
      OP_ROL: begin
        c_o             = ((am << 1) & mask) | word_t'(a_msb);
        status_o[CARRY] = a_msb;
      end
      OP_ROR: begin
        c_o             = (am >> 1) | (am[0] ? top : '0);
        status_o[CARRY] = am[0];
      end
      OP_SWAP: begin
        c_o    = bm;
        d_o    = am;
        upd_sz = 1'b0;
      end
      OP_INC: begin
        sum             = {1'b0, am} + (WORD_W+1)'(1);
        c_o             = sum[WORD_W-1:0] & mask;
        status_o[CARRY] = mode_i ? sum[WORD_W] : sum[HALF_W];
      end
      OP_DEC: begin
        c_o             = (am - word_t'(1)) & mask;
        status_o[CARRY] = (am == '0);
      end
      OP_ADD: begin
        sum             = {1'b0, am} + {1'b0, bm};
        c_o             = sum[WORD_W-1:0] & mask;
        status_o[CARRY] = mode_i ? sum[WORD_W] : sum[HALF_W];
      end
      OP_SUB: begin
        c_o             = (am - bm) & mask;
        status_o[CARRY] = (am < bm);
      end
      OP_CMP: begin
        status_o[SIGN] = (am < bm);
        status_o[ZERO] = (am == bm);
        upd_sz         = 1'b0;
      end
      OP_LDSR: begin
        c_o      = word_t'(a_i[2:0]);
        status_o = a_i[2:0];
        upd_sz   = 1'b0;
      end
      default: upd_sz = 1'b0;
    endcase
    if (upd_sz) begin
      status_o[SIGN] = msb_of(c_o, mode_i);
      status_o[ZERO] = (c_o == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Request/response controller sequencing one ALU op at a time.
// Revision : 1.0
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic              req_mode_i,
  input  logic [WORD_W-1:0] req_a_i,
  input  logic [WORD_W-1:0] req_b_i,
  input  logic [CNT_W-1:0]  req_cnt_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_c_o,
  output logic [WORD_W-1:0] rsp_d_o,
  output logic [2:0]        status_o,
  output logic              busy_o
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q;
  logic             mode_q;
  word_t            a_q, b_q, rsp_c_q, rsp_d_q;
  logic [CNT_W-1:0] cnt_q;
  status_t          status_q;

  word_t   core_c, core_d, pass_val;
  status_t core_status;
  logic    shift_op, pass_op, exec_last;

  alu_core u_core (
    .op_i     (op_q),
    .mode_i   (mode_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .status_i (status_q),
    .c_o      (core_c),
    .d_o      (core_d),
    .status_o (core_status)
  );

  assign shift_op  = is_shift(op_q);
  assign pass_op   = shift_op && (cnt_q == '0);
  assign exec_last = !shift_op || (cnt_q <= CNT_W'(1));
  assign pass_val  = a_q & width_mask(mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = ST_EXEC;
      ST_EXEC: if (exec_last)   state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ST_RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Shifts/rotates keep the running value in a_q; only the final step publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_NOP;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      rsp_c_q  <= '0;
      rsp_d_q  <= '0;
      status_q <= '0;
    end else if (state_q == ST_IDLE && req_valid_i) begin
      op_q   <= req_op_i;
      mode_q <= req_mode_i;
      a_q    <= req_a_i;
      b_q    <= req_b_i;
      cnt_q  <= req_cnt_i;
    end else if (state_q == ST_EXEC) begin
      if (pass_op) begin
        rsp_c_q  <= pass_val;
        rsp_d_q  <= '0;
        status_q <= {status_q[CARRY], msb_of(pass_val, mode_q), pass_val == '0};
      end else if (shift_op) begin
        a_q   <= core_c;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_c_q  <= core_c;
          rsp_d_q  <= '0;
          status_q <= core_status;
        end
      end else begin
        rsp_c_q  <= core_c;
        rsp_d_q  <= core_d;
        status_q <= core_status;
      end
    end
  end

  assign rsp_c_o  = rsp_c_q;
  assign rsp_d_o  = rsp_d_q;
  assign status_o = status_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench with a behavioural ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_mode;
  logic [3:0]  req_op;
  logic [19:0] req_a, req_b;
  logic [4:0]  req_cnt;
  logic        rsp_valid, rsp_ready, busy;
  logic [19:0] rsp_c, rsp_d;
  logic [2:0]  status;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  m_status = '0;
  logic [19:0] exp_c    = '0;
  logic [19:0] exp_d    = '0;
  logic [2:0]  exp_s    = '0;

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_mode_i  (req_mode),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cnt_i   (req_cnt),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_c_o     (rsp_c),
    .rsp_d_o     (rsp_d),
    .status_o    (status),
    .busy_o      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-operation reference: shifts/rotates computed in one go, not stepwise.
  task automatic model(input logic [3:0] op, input logic mode, input logic [19:0] a,
                       input logic [19:0] b, input int n, input logic [2:0] st,
                       output logic [19:0] c, output logic [19:0] d, output logic [2:0] so);
    longint unsigned w, mask, am, bm, r, k;
    logic cy;
    bit   sz;
    w    = mode ? 20 : 10;
    mask = (64'd1 << w) - 1;
    am   = a & mask;
    bm   = b & mask;
    r    = 0;
    d    = '0;
    so   = st;
    cy   = st[2];
    sz   = 1;
    k    = 0;
    if (op >= 5 && op <= 8 && n == 0) r = am;
    else case (op)
      0: sz = 0;
      1: r = ~am & mask;
      2: r = am & bm;
      3: r = am | bm;
      4: r = am ^ bm;
      5: begin r = (am << n) & mask; cy = (n <= w) ? (((am >> (w - n)) & 1) != 0) : 1'b0; end
      6: begin r = am >> n; cy = (n <= w) ? (((am >> (n - 1)) & 1) != 0) : 1'b0; end
      7: begin k = n % w; r = ((am << k) | (am >> (w - k))) & mask; cy = r[0]; end
      8: begin k = n % w; r = ((am >> k) | (am << (w - k))) & mask; cy = ((r >> (w - 1)) & 1) != 0; end
      9: begin r = bm; d = am[19:0]; sz = 0; end
      10: begin r = (am + 1) & mask; cy = (((am + 1) >> w) & 1) != 0; end
      11: begin r = (am - 1) & mask; cy = (am == 0); end
      12: begin r = (am + bm) & mask; cy = (((am + bm) >> w) & 1) != 0; end
      13: begin r = (am - bm) & mask; cy = (am < bm); end
      14: begin so = {st[2], am < bm, am == bm}; sz = 0; end
      default: begin r = a & 20'h7; so = a[2:0]; sz = 0; end
    endcase
    c = r[19:0];
    if (sz) so = {cy, ((r >> (w - 1)) & 1) != 0, r == 0};
  endtask

  // Response outputs must match the model whenever valid; status otherwise holds.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", busy, !req_ready);
      if (rsp_valid) begin
        chk("rsp_c", rsp_c, exp_c);
        chk("rsp_d", rsp_d, exp_d);
        chk("rsp_status", status, exp_s);
      end else begin
        chk("status_hold", status, m_status);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic mode, input logic [19:0] a,
                       input logic [19:0] b, input logic [4:0] cnt, input int hold,
                       input bit lit, input logic [19:0] lc, input logic [19:0] ld,
                       input logic [2:0] ls);
    int lat, k;
    model(op, mode, a, b, int'(cnt), m_status, exp_c, exp_d, exp_s);
    lat = (op >= OP_SHL && op <= OP_ROR && cnt != 0) ? int'(cnt) : 1;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_mode = mode;
    req_a = a; req_b = b; req_cnt = cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_mode = ~mode;
    req_a = ~a; req_b = ~b; req_cnt = ~cnt;
    k = 0;
    while (!rsp_valid && k < lat + 5) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, lat);
    m_status = exp_s;
    if (lit) begin
      chk("lit_c", rsp_c, lc);
      chk("lit_d", rsp_d, ld);
      chk("lit_status", status, ls);
    end
    repeat (hold) begin
      @(negedge clk);
      req_valid = 1'b1;
      chk("req_ready_busy", req_ready, 1'b0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("ready_back", req_ready, 1'b1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_mode = 1'b0;
    req_a = '0; req_b = '0; req_cnt = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_c", rsp_c, 20'h0);
    chk("rst_rsp_d", rsp_d, 20'h0);
    chk("rst_status", status, 3'b000);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_LDSR, 1'b1, 20'h00007, 20'h0, 5'd0, 0, 1, 20'h00007, 20'h0, 3'b111);

    // Abort a long rotate with reset; no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ROL; req_mode = 1'b1;
    req_a = 20'h80001; req_b = '0; req_cnt = 5'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_status = '0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_status", status, 3'b000);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", seen, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_status_after", status, 3'b000);

    issue(OP_ADD,  1'b1, 20'hFFFFF, 20'h00001, 5'd0,  0, 1, 20'h00000, 20'h0,     3'b101);
    issue(OP_ADD,  1'b0, 20'hFFFFF, 20'h00001, 5'd0,  0, 1, 20'h00000, 20'h0,     3'b101);
    issue(OP_INC,  1'b0, 20'h001FF, 20'h00000, 5'd0,  0, 1, 20'h00200, 20'h0,     3'b010);
    issue(OP_SWAP, 1'b1, 20'h12345, 20'hABCDE, 5'd0,  0, 1, 20'hABCDE, 20'h12345, 3'b010);
    issue(OP_ROL,  1'b1, 20'h80001, 20'h00000, 5'd4,  0, 1, 20'h00018, 20'h0,     3'b000);
    issue(OP_CMP,  1'b1, 20'h00005, 20'h00007, 5'd0,  5, 1, 20'h00000, 20'h0,     3'b010);
    issue(OP_SHL,  1'b1, 20'h80001, 20'h00000, 5'd20, 0, 1, 20'h00000, 20'h0,     3'b101);
    issue(OP_SHL,  1'b0, 20'h00201, 20'h00000, 5'd10, 0, 1, 20'h00000, 20'h0,     3'b101);
    issue(OP_SHR,  1'b1, 20'hFFFFF, 20'h00000, 5'd25, 0, 1, 20'h00000, 20'h0,     3'b001);
    issue(OP_ROR,  1'b0, 20'hFF201, 20'h00000, 5'd10, 1, 1, 20'h00201, 20'h0,     3'b110);

    issue(OP_SHL,  1'b1, 20'h80000, 20'h00000, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_SHR,  1'b0, 20'h00FF3, 20'h00000, 5'd3,  0, 0, '0, '0, '0);
    issue(OP_ROR,  1'b1, 20'h00003, 20'h00000, 5'd1,  0, 0, '0, '0, '0);
    issue(OP_ROL,  1'b0, 20'h003FF, 20'h00000, 5'd31, 0, 0, '0, '0, '0);
    issue(OP_SUB,  1'b1, 20'h00005, 20'h00007, 5'd0,  2, 0, '0, '0, '0);
    issue(OP_DEC,  1'b0, 20'hFFC00, 20'h00000, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_NOT,  1'b0, 20'h000F0, 20'h00000, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_AND,  1'b1, 20'hF0F0F, 20'h0FF00, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_OR,   1'b1, 20'hF0000, 20'h0000F, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_XOR,  1'b0, 20'h003AA, 20'h003AA, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_NOP,  1'b1, 20'h12345, 20'h54321, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_CMP,  1'b0, 20'hFF005, 20'h00005, 5'd0,  0, 0, '0, '0, '0);
    issue(OP_SUB,  1'b0, 20'h00007, 20'h00005, 5'd0,  0, 0, '0, '0, '0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
